preg_recovery_ctrl: RTL and testbench

// Branch-checkpoint and mispredict-recovery sequencer for the physical-register free list.

---
 rtl/preg_recovery_ctrl_pkg.sv | 30 +++
 rtl/preg_recovery_ctrl_lowest_n_select.sv | 35 +++
 rtl/preg_recovery_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_preg_recovery_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/preg_recovery_ctrl_pkg.sv
// Shared types and default sizes for the physical-register recovery sequencer.
`ifndef N
`define N 4
`endif
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif
`ifndef NUM_BRANCH_CKPT
`define NUM_BRANCH_CKPT 8
`endif

package preg_recovery_ctrl_pkg;

  localparam int unsigned SCALAR_N        = `N;
  localparam int unsigned PHYS_REGS       = `PHYS_REG_SZ_R10K;
  localparam int unsigned NUM_CKPT_DEF    = `NUM_BRANCH_CKPT;
  localparam int unsigned PHYS_REG_IDX_W  = $clog2(PHYS_REGS);
  localparam int unsigned NUM_SCALAR_BITS = $clog2(SCALAR_N + 1);
  localparam int unsigned CKPT_ID_W       = $clog2(NUM_CKPT_DEF);

  typedef logic [PHYS_REG_IDX_W-1:0]  PHYS_REG_IDX;
  typedef logic [CKPT_ID_W-1:0]       CKPT_ID;
  typedef logic [NUM_SCALAR_BITS-1:0] SCALAR_CNT;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } rec_state_t;

endpackage

// File: rtl/preg_recovery_ctrl_lowest_n_select.sv
// Picks the lowest N set bits of a register bitmap, in ascending order,
// and returns their indices, how many were picked and the bitmap without them.
module lowest_n_select
  import preg_recovery_ctrl_pkg::*;
#(
  parameter  int unsigned N     = SCALAR_N,
  parameter  int unsigned PREGS = PHYS_REGS,
  localparam int unsigned IDXW  = $clog2(PREGS),
  localparam int unsigned CNTW  = $clog2(N + 1)
) (
  input  logic [PREGS-1:0]         vec,
  output logic [N-1:0][IDXW-1:0]   idx,
  output logic [CNTW-1:0]          count,
  output logic [PREGS-1:0]         cleared
);

  // Ascending priority scan; lane n receives the n-th set bit found.
  always_comb begin
    int unsigned n;
    n       = 0;
    idx     = '0;
    cleared = vec;
    for (int unsigned b = 0; b < PREGS; b++) begin
      if (vec[b] && (n < N)) begin
        for (int unsigned l = 0; l < N; l++) begin
          if (l == n) idx[l] = IDXW'(b);
        end
        cleared[b] = 1'b0;
        n++;
      end
    end
    count = CNTW'(n);
  end

endmodule

// File: rtl/preg_recovery_ctrl.sv
// Branch-checkpoint tracking and mispredict drain of physical registers
// back to the free list, with dispatch stalled while a drain runs.
module preg_recovery_ctrl
  import preg_recovery_ctrl_pkg::*;
#(
  parameter  int unsigned N        = SCALAR_N,
  parameter  int unsigned PREGS    = PHYS_REGS,
  parameter  int unsigned NUM_CKPT = NUM_CKPT_DEF,
  localparam int unsigned IDXW     = $clog2(PREGS),
  localparam int unsigned CIDW     = $clog2(NUM_CKPT),
  localparam int unsigned CNTW     = $clog2(N + 1),
  localparam int unsigned LANEW    = (N > 1) ? $clog2(N) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N-1:0]             alloc_valid,
  input  logic [N-1:0][IDXW-1:0]   alloc_preg,
  input  logic                     ckpt_take,
  input  logic [LANEW-1:0]         ckpt_lane,
  output logic [CIDW-1:0]          ckpt_id,
  output logic                     ckpt_full,
  input  logic                     resolve_valid,
  input  logic [CIDW-1:0]          resolve_id,
  input  logic                     resolve_mispred,
  output logic [N-1:0][IDXW-1:0]   recl_preg,
  output logic [CNTW-1:0]          recl_count,
  output logic                     dispatch_stall
);

  rec_state_t state_q, state_nxt;

  logic [NUM_CKPT-1:0] live_q, done_q;
  logic [PREGS-1:0]    mask_q [NUM_CKPT];
  logic [PREGS-1:0]    drain_q, drain_nxt;
  logic [CIDW-1:0]     head_q, tail_q;
  logic [CIDW:0]       cnt_q, cnt_nxt;

  logic [N-1:0][IDXW-1:0] sel_idx;
  logic [CNTW-1:0]        sel_cnt;
  logic [PREGS-1:0]       sel_left, sel_bits;

  logic                in_drain;
  logic [PREGS-1:0]    alloc_bits, young_bits;
  logic                res_live, mispred, correct, take, track;
  logic [NUM_CKPT-1:0] kill, retire;
  logic [CIDW:0]       adv;

  lowest_n_select #(
    .N     (N),
    .PREGS (PREGS)
  ) u_sel (
    .vec     (drain_q),
    .idx     (sel_idx),
    .count   (sel_cnt),
    .cleared (sel_left)
  );

  assign sel_bits = drain_q & ~sel_left;
  assign in_drain = (state_q == DRAIN);

  // Bitmaps of this cycle's allocations: all lanes, and lanes younger than the branch.
  always_comb begin
    alloc_bits = '0;
    young_bits = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (alloc_valid[i]) begin
        alloc_bits[alloc_preg[i]] = 1'b1;
        if (LANEW'(i) > ckpt_lane) young_bits[alloc_preg[i]] = 1'b1;
      end
    end
  end

  // Classify the resolve and decide whether dispatch activity is applied.
  always_comb begin
    res_live = resolve_valid && live_q[resolve_id];
    mispred  = res_live && resolve_mispred;
    correct  = res_live && !resolve_mispred;
    track    = !in_drain && !mispred;
    take     = track && ckpt_take && !ckpt_full;
  end

  // Slots squashed by a mispredict, and done slots retired contiguously from head.
  // Live slots always span head..tail-1, so age relative to head orders them.
  always_comb begin
    logic [CIDW-1:0]     k_age, s_age, s;
    logic [NUM_CKPT-1:0] done_n;
    logic                run;
    kill   = '0;
    retire = '0;
    adv    = '0;
    run    = 1'b1;
    k_age  = resolve_id - head_q;
    for (int unsigned i = 0; i < NUM_CKPT; i++) begin
      s_age = CIDW'(i) - head_q;
      if (mispred && live_q[i] && (s_age >= k_age)) kill[i] = 1'b1;
    end
    done_n = done_q;
    if (correct) done_n[resolve_id] = 1'b1;
    for (int unsigned off = 0; off < NUM_CKPT; off++) begin
      s = head_q + CIDW'(off);
      if (run && live_q[s] && done_n[s]) begin
        retire[s] = 1'b1;
        adv       = adv + (CIDW+1)'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  // Next drain bitmap and live-slot count.
  // A mispredict mid-drain must exclude this cycle's reclaimed regs from the new mask.
  always_comb begin
    drain_nxt = in_drain ? sel_left : '0;
    cnt_nxt   = cnt_q - adv + (CIDW+1)'(take);
    if (mispred) begin
      drain_nxt = in_drain ? (mask_q[resolve_id] & ~sel_bits)
                           : (mask_q[resolve_id] | alloc_bits);
      cnt_nxt   = {1'b0, resolve_id - head_q};
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_nxt;
  end

  // FSM next state: stay draining while any reg is left to reclaim.
  always_comb begin
    state_nxt = IDLE;
    if (drain_nxt != '0) state_nxt = DRAIN;
  end

  // FSM outputs, all derived from registered state.
  always_comb begin
    dispatch_stall = in_drain;
    recl_count     = in_drain ? sel_cnt : '0;
    recl_preg      = in_drain ? sel_idx : '0;
    ckpt_full      = (cnt_q == (CIDW+1)'(NUM_CKPT));
    ckpt_id        = tail_q;
  end

  // Checkpoint slots, pointers and drain bitmap.
  always_ff @(posedge clock) begin
    if (reset) begin
      live_q  <= '0;
      done_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      drain_q <= '0;
      for (int unsigned s = 0; s < NUM_CKPT; s++) mask_q[s] <= '0;
    end else begin
      drain_q <= drain_nxt;
      cnt_q   <= cnt_nxt;
      head_q  <= head_q + adv[CIDW-1:0];
      if (mispred)   tail_q <= resolve_id;
      else if (take) tail_q <= tail_q + CIDW'(1);
      for (int unsigned s = 0; s < NUM_CKPT; s++) begin
        if (kill[s] || retire[s]) begin
          live_q[s] <= 1'b0;
          done_q[s] <= 1'b0;
          mask_q[s] <= '0;
        end else if (take && (tail_q == CIDW'(s))) begin
          live_q[s] <= 1'b1;
          done_q[s] <= 1'b0;
          mask_q[s] <= young_bits;
        end else begin
          if (correct && (resolve_id == CIDW'(s))) done_q[s] <= 1'b1;
          if (live_q[s]) mask_q[s] <= (mask_q[s] | (track ? alloc_bits : '0)) & ~sel_bits;
        end
      end
    end
  end

  // Dispatch must stay quiet while the drain runs.
  a_no_dispatch_in_drain: assert property (@(posedge clock) disable iff (reset)
    dispatch_stall |-> ((alloc_valid == '0) && !ckpt_take));

endmodule

// File: tb/tb_preg_recovery_ctrl.sv
// Bench for preg_recovery_ctrl: set-based reference model plus directed and random stimulus.
module tb_preg_recovery_ctrl;

  localparam int N        = 4;
  localparam int PREGS    = 64;
  localparam int NUM_CKPT = 8;
  localparam int IDXW     = 6;
  localparam int CIDW     = 3;
  localparam int CNTW     = 3;

  logic                   clock = 1'b0;
  logic                   reset;
  logic [N-1:0]           alloc_valid;
  logic [N-1:0][IDXW-1:0] alloc_preg;
  logic                   ckpt_take;
  logic [1:0]             ckpt_lane;
  logic [CIDW-1:0]        ckpt_id;
  logic                   ckpt_full;
  logic                   resolve_valid;
  logic [CIDW-1:0]        resolve_id;
  logic                   resolve_mispred;
  logic [N-1:0][IDXW-1:0] recl_preg;
  logic [CNTW-1:0]        recl_count;
  logic                   dispatch_stall;

  preg_recovery_ctrl #(.N(N), .PREGS(PREGS), .NUM_CKPT(NUM_CKPT)) dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_preg(alloc_preg),
    .ckpt_take(ckpt_take), .ckpt_lane(ckpt_lane),
    .ckpt_id(ckpt_id), .ckpt_full(ckpt_full),
    .resolve_valid(resolve_valid), .resolve_id(resolve_id), .resolve_mispred(resolve_mispred),
    .recl_preg(recl_preg), .recl_count(recl_count), .dispatch_stall(dispatch_stall)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model: age-ordered list of live checkpoint ids, a reg set per slot, a drain set.
  int             m_q[$];
  bit [PREGS-1:0] m_set [NUM_CKPT];
  bit             m_done[NUM_CKPT];
  bit [PREGS-1:0] m_drain;
  int             m_tail;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic void lowest(input bit [PREGS-1:0] s, output int cnt,
                                 output logic [N-1:0][IDXW-1:0] lanes, output bit [PREGS-1:0] taken);
    cnt = 0; lanes = '0; taken = '0;
    for (int b = 0; b < PREGS; b++) begin
      if (s[b] && cnt < N) begin
        lanes[cnt] = IDXW'(b);
        taken[b]   = 1'b1;
        cnt++;
      end
    end
  endfunction

  function automatic logic [N-1:0][IDXW-1:0] pk(input int a, input int b, input int c, input int d);
    logic [N-1:0][IDXW-1:0] r;
    r[0] = IDXW'(a); r[1] = IDXW'(b); r[2] = IDXW'(c); r[3] = IDXW'(d);
    return r;
  endfunction

  task automatic model_step();
    bit [PREGS-1:0] gone, a_all, a_young;
    logic [N-1:0][IDXW-1:0] dummy;
    int cnt, pos, id;
    bit drn, full0, mp;
    if (reset) begin
      m_q.delete();
      m_tail  = 0;
      m_drain = '0;
      for (int s = 0; s < NUM_CKPT; s++) begin m_set[s] = '0; m_done[s] = 1'b0; end
      return;
    end
    drn   = (m_drain != '0);
    full0 = (m_q.size() == NUM_CKPT);
    lowest(m_drain, cnt, dummy, gone);
    m_drain &= ~gone;
    for (int s = 0; s < NUM_CKPT; s++) m_set[s] &= ~gone;
    a_all = '0; a_young = '0;
    for (int l = 0; l < N; l++) begin
      if (alloc_valid[l]) begin
        a_all[alloc_preg[l]] = 1'b1;
        if (l > int'(ckpt_lane)) a_young[alloc_preg[l]] = 1'b1;
      end
    end
    pos = -1;
    if (resolve_valid) foreach (m_q[i]) if (m_q[i] == int'(resolve_id)) pos = i;
    mp = (pos >= 0) && resolve_mispred;
    if (pos >= 0) begin
      id = int'(resolve_id);
      if (resolve_mispred) begin
        m_drain = drn ? m_set[id] : (m_set[id] | a_all);
        while (m_q.size() > pos) begin
          m_set[m_q[m_q.size()-1]]  = '0;
          m_done[m_q[m_q.size()-1]] = 1'b0;
          void'(m_q.pop_back());
        end
        m_tail = id;
      end else begin
        m_done[id] = 1'b1;
        while (m_q.size() > 0 && m_done[m_q[0]]) begin
          m_set[m_q[0]]  = '0;
          m_done[m_q[0]] = 1'b0;
          void'(m_q.pop_front());
        end
      end
    end
    if (!drn && !mp) begin
      foreach (m_q[i]) m_set[m_q[i]] |= a_all;
      if (ckpt_take && !full0) begin
        m_q.push_back(m_tail);
        m_set[m_tail]  = a_young;
        m_done[m_tail] = 1'b0;
        m_tail = (m_tail + 1) % NUM_CKPT;
      end
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // Compare every cycle, on the falling edge.
  initial forever begin
    @(negedge clock);
    if (chk_en) begin
      int cnt;
      logic [N-1:0][IDXW-1:0] lanes;
      bit [PREGS-1:0] taken;
      lowest(m_drain, cnt, lanes, taken);
      check("dispatch_stall", 64'(dispatch_stall), 64'(m_drain != '0));
      check("recl_count",     64'(recl_count),     64'(cnt));
      check("recl_preg",      64'(recl_preg),      64'(lanes));
      check("ckpt_full",      64'(ckpt_full),      64'(m_q.size() == NUM_CKPT));
      check("ckpt_id",        64'(ckpt_id),        64'(m_tail));
    end
  end

  task automatic idle_inputs();
    alloc_valid = '0; alloc_preg = '0; ckpt_take = 1'b0; ckpt_lane = '0;
    resolve_valid = 1'b0; resolve_id = '0; resolve_mispred = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    idle_inputs();
  endtask

  task automatic resolve(input int id, input bit mis);
    resolve_valid = 1'b1; resolve_id = CIDW'(id); resolve_mispred = mis;
  endtask

  task automatic expect_out(input string nm, input int cnt, input logic [N-1:0][IDXW-1:0] lanes,
                            input bit stall, input int id, input bit full);
    check({nm, "_count"}, 64'(recl_count), 64'(cnt));
    check({nm, "_preg"},  64'(recl_preg),  64'(lanes));
    check({nm, "_stall"}, 64'(dispatch_stall), 64'(stall));
    check({nm, "_id"},    64'(ckpt_id),    64'(id));
    check({nm, "_full"},  64'(ckpt_full),  64'(full));
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk_en = 1'b1;
    tick();
    expect_out("reset_idle", 0, '0, 0, 0, 0);

    // Branch on lane 0, younger lanes allocate 40..42, then mispredict.
    ckpt_take = 1'b1; alloc_valid = 4'b1110; alloc_preg = pk(0, 40, 41, 42);
    tick();
    check("take_id", 64'(ckpt_id), 64'd1);
    resolve(0, 1);
    tick();
    expect_out("drain3", 3, pk(40, 41, 42, 0), 1, 0, 0);
    tick();
    expect_out("drain3_end", 0, '0, 0, 0, 0);

    // Nine regs after checkpoint 2, allocated out of order.
    ckpt_take = 1'b1; tick();
    ckpt_take = 1'b1; tick();
    ckpt_take = 1'b1; alloc_valid = 4'b1110; alloc_preg = pk(0, 52, 50, 51); tick();
    alloc_valid = 4'b1111; alloc_preg = pk(56, 53, 55, 54); tick();
    alloc_valid = 4'b0011; alloc_preg = pk(58, 57, 0, 0); tick();
    check("pre9_id", 64'(ckpt_id), 64'd3);
    resolve(2, 1); tick();
    expect_out("d9_c1", 4, pk(50, 51, 52, 53), 1, 2, 0);
    tick();
    expect_out("d9_c2", 4, pk(54, 55, 56, 57), 1, 2, 0);
    tick();
    expect_out("d9_c3", 1, pk(58, 0, 0, 0), 1, 2, 0);
    tick();
    expect_out("d9_end", 0, '0, 0, 2, 0);

    // Mispredict on a slot whose regs were already reclaimed: nothing to drain.
    resolve(0, 1); tick();
    expect_out("empty_mp", 0, '0, 0, 0, 0);

    // Nested mispredict: younger slot first, older one during the first drain cycle.
    ckpt_take = 1'b1; alloc_valid = 4'b1110; alloc_preg = pk(0, 10, 11, 12); tick();
    ckpt_take = 1'b1; alloc_valid = 4'b1111; alloc_preg = pk(13, 14, 15, 16); tick();
    alloc_valid = 4'b0001; alloc_preg = pk(17, 0, 0, 0); tick();
    resolve(1, 1); tick();
    expect_out("nest_c1", 4, pk(14, 15, 16, 17), 1, 1, 0);
    resolve(0, 1); tick();
    expect_out("nest_c2", 4, pk(10, 11, 12, 13), 1, 0, 0);
    tick();
    expect_out("nest_end", 0, '0, 0, 0, 0);

    // Allocation squashed by a same-cycle mispredict is reclaimed.
    ckpt_take = 1'b1; tick();
    alloc_valid = 4'b0001; alloc_preg = pk(20, 0, 0, 0); resolve(0, 1); tick();
    expect_out("same_cyc", 1, pk(20, 0, 0, 0), 1, 0, 0);
    tick();
    expect_out("same_cyc_end", 0, '0, 0, 0, 0);

    // Fill all slots, retire the head, refill, then an out-of-order correct resolve.
    for (int i = 0; i < NUM_CKPT; i++) begin ckpt_take = 1'b1; tick(); end
    expect_out("full", 0, '0, 0, 0, 1);
    resolve(0, 0); tick();
    expect_out("free_head", 0, '0, 0, 0, 0);
    ckpt_take = 1'b1; tick();
    expect_out("refull", 0, '0, 0, 1, 1);
    resolve(3, 0); tick();
    expect_out("ooo_resolve", 0, '0, 0, 1, 1);
    resolve(1, 1); tick();
    expect_out("flush_all", 0, '0, 0, 1, 0);

    // Reset in the middle of a drain.
    ckpt_take = 1'b1; alloc_valid = 4'b1110; alloc_preg = pk(0, 30, 31, 32); tick();
    alloc_valid = 4'b1111; alloc_preg = pk(33, 34, 35, 36); tick();
    resolve(1, 1); tick();
    expect_out("pre_rst", 4, pk(30, 31, 32, 33), 1, 1, 0);
    reset = 1'b1; tick();
    reset = 1'b0;
    expect_out("mid_rst", 0, '0, 0, 0, 0);

    // Random traffic, legal with respect to the model's stall and full state.
    for (int c = 0; c < 4000; c++) begin
      if (m_drain == '0) begin
        for (int l = 0; l < N; l++) begin
          alloc_valid[l] = ($urandom_range(1, 0) == 1);
          alloc_preg[l]  = IDXW'($urandom_range(PREGS - 1, 0));
        end
        if (m_q.size() < NUM_CKPT && $urandom_range(3, 0) == 0) begin
          ckpt_take = 1'b1;
          ckpt_lane = 2'($urandom_range(N - 1, 0));
        end
      end
      if ($urandom_range(9, 0) < 3) begin
        resolve_valid   = 1'b1;
        if (m_q.size() > 0 && $urandom_range(3, 0) != 0)
          resolve_id = CIDW'(m_q[$urandom_range(m_q.size() - 1, 0)]);
        else
          resolve_id = CIDW'($urandom_range(NUM_CKPT - 1, 0));
        resolve_mispred = ($urandom_range(4, 0) == 0);
      end
      tick();
    end

    for (int w = 0; w < 40 && m_drain != '0; w++) tick();
    check("final_stall", 64'(dispatch_stall), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
